// File: rtl/pio_in_edge_irq.sv
// Purpose: Avalon-MM input PIO: sync, debounce, edge capture and maskable level irq per bit.
// Latency: zero-wait-state reads; an input change is accepted DEBOUNCE_CYCLES+1 edges after first sampling.
// Backpressure: none; the slave always accepts reads and writes in the cycle they are presented.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   address[1:0]        0 DATA (RO), 1 reserved, 2 IRQ_MASK (RW), 3 EDGECAP (write-1-to-clear)
//   chipselect, write_n write strobe is chipselect & ~write_n
//   writedata[31:0]     write data
//   in_port[WIDTH-1:0]  asynchronous external inputs
//   readdata[31:0]      combinational read data (independent of chipselect)
//   irq                 level interrupt, |(edge_capture & irq_mask)
module pio_in_edge_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic             wr_en;

  // Only the low WIDTH bits of writedata carry register contents.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  // A bit is accepted on the edge where it has differed for the full count;
  // the edge detector looks at this same-cycle update, not at a delayed copy.
  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      update[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise = update & sync2;
  assign fall = update & ~sync2;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign ev = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign ev = fall;
    end else begin : g_any
      assign ev = rise | fall;
    end
  endgenerate

  assign clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sync2        <= '0;
      stable       <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;

      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end

      if (wr_en && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end

      // Set is applied after clear so an event coinciding with a W1C is kept.
      edge_capture <= (edge_capture & ~clr) | ev;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      ADDR_MASK:    readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: two instances share all inputs, one capturing
// falling edges (dut_f) and one capturing rising edges (dut_r), DEBOUNCE=4.
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] rd_f, rd_r;
  logic        irq_f, irq_r;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_f (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f)
  );

  pio_in_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r)
  );

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [31:0] ef;
    logic        irqf;
    logic [31:0] er;
    logic        irqr;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input string name, input logic [1:0] a, input logic [31:0] ef, input logic [31:0] er);
    address = a;
    #1;
    chk({name, " f"}, rd_f, ef);
    chk({name, " r"}, rd_r, er);
  endtask

  task automatic irq2(input string name, input logic ef, input logic er);
    chk({name, " irq f"}, 32'(irq_f), 32'(ef));
    chk({name, " irq r"}, 32'(irq_r), 32'(er));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            addr  cs    wn    wd            ef     irqf  er     irqr
    tbl[0]  = '{2'd3, 1'b0, 1'b1, 32'h0,        32'h4, 1'b0, 32'h0, 1'b0};
    tbl[1]  = '{2'd2, 1'b1, 1'b0, 32'h4,        32'h0, 1'b0, 32'h0, 1'b0};
    tbl[2]  = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h4, 1'b1, 32'h4, 1'b0};
    tbl[3]  = '{2'd2, 1'b1, 1'b0, 32'h0,        32'h4, 1'b1, 32'h4, 1'b0};
    tbl[4]  = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0, 32'h0, 1'b0};
    tbl[5]  = '{2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[6]  = '{2'd1, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0, 32'h0, 1'b0};
    tbl[7]  = '{2'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h8, 1'b0, 32'h8, 1'b0};
    tbl[8]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h8, 1'b0, 32'h8, 1'b0};
    tbl[9]  = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[10] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'hF, 1'b1, 32'hF, 1'b0};
    tbl[11] = '{2'd3, 1'b0, 1'b0, 32'hF,        32'h4, 1'b1, 32'h0, 1'b0};
    tbl[12] = '{2'd3, 1'b1, 1'b1, 32'hF,        32'h4, 1'b1, 32'h0, 1'b0};
    tbl[13] = '{2'd3, 1'b1, 1'b0, 32'h4,        32'h4, 1'b1, 32'h0, 1'b0};
    tbl[14] = '{2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0, 32'h0, 1'b0};

    // Reset: every address reads 0, no interrupt.
    #2 reset_n = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) rd2("reset read", 2'(a), 32'h0, 32'h0);
    irq2("reset", 1'b0, 1'b0);
    tick();
    tick();

    // Inputs held high through reset release: accepted at E5, rising edge only.
    reset_n = 1'b1;
    repeat (5) tick();
    rd2("t1 data E4", 2'd0, 32'h0, 32'h0);
    tick();
    rd2("t1 data E5", 2'd0, 32'hF, 32'hF);
    rd2("t1 edgecap", 2'd3, 32'h0, 32'hF);
    irq2("t1 masked", 1'b0, 1'b0);
    wr(2'd3, 32'hF);
    rd2("t1 edgecap cleared", 2'd3, 32'h0, 32'h0);
    wr(2'd2, 32'h1);

    // Falling edge on bit0, irq asserted in the capture cycle.
    in_port = 4'hE;
    repeat (5) tick();
    rd2("t2 data E4", 2'd0, 32'hF, 32'hF);
    irq2("t2 E4", 1'b0, 1'b0);
    tick();
    rd2("t2 data E5", 2'd0, 32'hE, 32'hE);
    rd2("t2 edgecap", 2'd3, 32'h1, 32'h0);
    irq2("t2 E5", 1'b1, 1'b0);

    // Three-cycle glitch on bit1 is rejected.
    in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (4) tick();
    rd2("t3 data after glitch", 2'd0, 32'hE, 32'hE);
    rd2("t3 edgecap after glitch", 2'd3, 32'h1, 32'h0);
    // A held low on bit1 must take the full count again (counter restarted).
    in_port = 4'hC;
    repeat (5) tick();
    rd2("t3 data E4", 2'd0, 32'hE, 32'hE);
    tick();
    rd2("t3 data E5", 2'd0, 32'hC, 32'hC);
    rd2("t3 edgecap E5", 2'd3, 32'h3, 32'h0);

    // Clear of bit0 coinciding with a new bit0 event.
    in_port = 4'hD;
    repeat (6) tick();
    rd2("t4 edgecap after rise", 2'd3, 32'h3, 32'h1);
    irq2("t4 after rise", 1'b1, 1'b1);
    in_port = 4'hC;
    repeat (5) tick();
    address    = 2'd3;
    writedata  = 32'h1;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    rd2("t4 data", 2'd0, 32'hC, 32'hC);
    rd2("t4 set wins", 2'd3, 32'h3, 32'h0);
    irq2("t4 set wins", 1'b1, 1'b0);
    wr(2'd3, 32'h1);
    rd2("t4 later clear", 2'd3, 32'h2, 32'h0);
    irq2("t4 later clear", 1'b0, 1'b0);

    // Mask and register map vectors, with capture bit2 set.
    in_port = 4'h8;
    repeat (6) tick();
    rd2("t5 data", 2'd0, 32'h8, 32'h8);
    rd2("t5 edgecap", 2'd3, 32'h6, 32'h0);
    wr(2'd3, 32'h2);
    wr(2'd2, 32'h0);
    for (int i = 0; i < 15; i++) begin
      address    = tbl[i].addr;
      chipselect = tbl[i].cs;
      write_n    = tbl[i].wn;
      writedata  = tbl[i].wd;
      #1;
      chk($sformatf("vec%0d rd f", i), rd_f, tbl[i].ef);
      chk($sformatf("vec%0d rd r", i), rd_r, tbl[i].er);
      chk($sformatf("vec%0d irq f", i), 32'(irq_f), 32'(tbl[i].irqf));
      chk($sformatf("vec%0d irq r", i), 32'(irq_r), 32'(tbl[i].irqr));
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    // Asynchronous reset mid-count with irq high beforehand.
    in_port = 4'h0;
    repeat (6) tick();
    rd2("t6 edgecap", 2'd3, 32'h8, 32'h0);
    irq2("t6 before reset", 1'b1, 1'b0);
    in_port = 4'hF;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    irq2("t6 async reset", 1'b0, 1'b0);
    for (int a = 0; a < 4; a++) rd2("t6 reset read", 2'(a), 32'h0, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    rd2("t6 data E4", 2'd0, 32'h0, 32'h0);
    tick();
    rd2("t6 data E5", 2'd0, 32'hF, 32'hF);
    rd2("t6 edgecap", 2'd3, 32'h0, 32'hF);
    irq2("t6 mask reset", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
